// File: rtl/interval_timer_arb.sv
// Round-robin scheduler that shares one WIDTH-bit interval counter among NUM_REQ requesters.
// Optional INTERVAL_ARB_STATS_EN adds an n_done completed-interval counter output.
module interval_timer_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   dur,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [WIDTH-1:0]           count
`ifdef INTERVAL_ARB_STATS_EN
    ,
    output logic [31:0]                n_done
`endif
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [WIDTH-1:0]     tgt_q, tgt_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;

    logic [WIDTH-1:0]     dur_w [NUM_REQ];
    logic [WIDTH-1:0]     dur_sel;
    logic                 owner_req;
    logic [IW-1:0]        rr_next;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [IW-1:0]        k;
    logic [NUM_REQ-1:0]   win_onehot;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_dur
        assign dur_w[g] = dur[g*WIDTH +: WIDTH];
    end

    assign dur_sel   = dur_w[owner_q];
    assign owner_req = req[owner_q];
    assign rr_next   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

    // First set request at or after the round-robin pointer, wrapping.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        k          = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IW'((32'(rr_q) + 32'(i)) % NUM_REQ);
            if (req[k] && !win_found) begin
                win_found = 1'b1;
                win_idx   = k;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (IW'(i) == win_idx);
        end
    end

    // Next-state and next-output logic; an owner dropping req aborts without done.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        tgt_d   = tgt_q;
        count_d = '0;
        gnt_d   = gnt_q;
        done_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    state_d = S_LOAD;
                    owner_d = win_idx;
                    gnt_d   = win_onehot;
                end
            end
            S_LOAD: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    rr_d    = rr_next;
                end else begin
                    state_d = S_RUN;
                    tgt_d   = (dur_sel == '0) ? WIDTH'(1) : dur_sel;
                end
            end
            S_RUN: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    rr_d    = rr_next;
                end else if (count_q == tgt_q - WIDTH'(1)) begin
                    state_d = S_DONE;
                    done_d  = gnt_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                rr_d    = rr_next;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            tgt_q   <= '0;
            count_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            tgt_q   <= tgt_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;

`ifdef INTERVAL_ARB_STATS_EN
    logic [31:0] n_done_q;

    // Completed intervals only; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_done_q <= '0;
        end else if (state_q == S_DONE) begin
            n_done_q <= n_done_q + 32'd1;
        end
    end

    assign n_done = n_done_q;
`endif

endmodule
